// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: RV32I opcode constants, FSM state type, field-set struct,
// and the encode / legality helpers used by instr_encoder.
package rv_enc_pkg;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OP_LOAD   = 5'd0;
    localparam logic [4:0] OP_OP_IMM = 5'd4;
    localparam logic [4:0] OP_AUIPC  = 5'd5;
    localparam logic [4:0] OP_STORE  = 5'd8;
    localparam logic [4:0] OP_OP     = 5'd12;
    localparam logic [4:0] OP_LUI    = 5'd13;
    localparam logic [4:0] OP_BRANCH = 5'd24;
    localparam logic [4:0] OP_JALR   = 5'd25;
    localparam logic [4:0] OP_JAL    = 5'd27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } enc_state_e;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  funct3;
        logic        sel;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } field_set_t;

    // Unrecognised opcodes fall through to the R-format layout.
    function automatic logic [31:0] encode(input field_set_t f);
        logic [31:0] w;
        w = {1'b0, f.sel, 5'b0, f.rs2, f.rs1, f.funct3, f.rd, f.opcode, 2'b11};
        case (f.opcode)
            OP_OP_IMM: begin
                if (f.funct3 == 3'd1 || f.funct3 == 3'd5)
                    w = {1'b0, f.sel, 5'b0, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode, 2'b11};
                else
                    w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode, 2'b11};
            end
            OP_LOAD:   w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode, 2'b11};
            OP_JALR:   w = {f.imm[11:0], f.rs1, 3'b000, f.rd, f.opcode, 2'b11};
            OP_STORE:  w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode, 2'b11};
            OP_BRANCH: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                            f.imm[4:1], f.imm[11], f.opcode, 2'b11};
            OP_LUI,
            OP_AUIPC:  w = {f.imm[31:12], f.rd, f.opcode, 2'b11};
            OP_JAL:    w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode, 2'b11};
            default:   ;
        endcase
        return w;
    endfunction

    function automatic logic is_legal(input field_set_t f);
        logic ok;
        ok = 1'b0;
        case (f.opcode)
            OP_LOAD,
            OP_STORE:  ok = (f.funct3 == 3'd2);
            OP_BRANCH: ok = (f.funct3 != 3'd2) && (f.funct3 != 3'd3);
            OP_OP_IMM,
            OP_AUIPC,
            OP_OP,
            OP_LUI,
            OP_JALR,
            OP_JAL:    ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: DEPTH-entry synchronous FIFO carrying {instr, addr}.
// Read data reads as zero while empty so the output port is clean out of reset.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; data validity is tracked by the pointers.
    // NOTE: the array has no reset -- pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Pointer update; push and pop in the same cycle keep occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns RV32I field sets into encoded words with sequential
// addresses, buffered in enc_fifo toward an instruction-memory writer.
// Optional macro INSTR_ENCODER_ILLEGAL_CHECK_EN: reject illegal field sets
// (pulse err_illegal, nothing pushed, address not advanced).
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        stop,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_sel,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        busy,
    output logic        done,
    output logic        err_illegal
);

    enc_state_e  r_state;
    enc_state_e  w_next_state;
    logic [31:0] r_addr;
    field_set_t  w_fs;
    logic        w_accept;
    logic        w_legal;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic [63:0] w_rd_data;

    assign w_fs = '{opcode: in_opcode, funct3: in_funct3, sel: in_sel, rd: in_rd,
                    rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    assign in_ready  = (r_state == ST_RUN) && !w_full;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign out_valid = !w_empty;
    assign out_instr = w_rd_data[63:32];
    assign out_addr  = w_rd_data[31:0];
    assign busy      = (r_state != ST_IDLE);

`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
    logic r_err_illegal;

    assign w_legal     = is_legal(w_fs);
    assign err_illegal = r_err_illegal;

    // One-cycle flag for each accepted-but-rejected field set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err_illegal <= 1'b0;
        else     r_err_illegal <= w_accept && !w_legal;
    end
`else
    assign w_legal     = 1'b1;
    assign err_illegal = 1'b0;
`endif

    // Address of the next word to push: loaded on run start, +4 per push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_addr <= '0;
        else if (r_state == ST_IDLE && start)
            r_addr <= base_addr;
        else if (w_push)
            r_addr <= r_addr + 32'd4;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state and done; start beats stop in IDLE, stray pulses ignored.
    // NOTE: combinational logic uses blocking assignments with defaults first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_RUN;
            ST_RUN:   if (stop)  w_next_state = ST_DRAIN;
            ST_DRAIN: begin
                if (w_empty) begin
                    w_next_state = ST_IDLE;
                    done         = 1'b1;
                end
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({encode(w_fs), r_addr}),
        .i_pop   (out_ready),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed RV32I words.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_sel = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        busy;
    logic        done;
    logic        err_illegal;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] exp_w;
    logic [31:0] exp_addr = '0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .stop        (stop),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_sel      (in_sel),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive/sample point: just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic with_stop);
        start     = 1'b1;
        stop      = with_stop;
        base_addr = base;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic push_fs(input logic [4:0] op, input logic [2:0] f3, input logic sel,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic [31:0] exp_instr, input bit legal);
        int n;
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_sel = sel;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        if (legal) begin
            exp_q.push_back({exp_instr, exp_addr});
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: every handshake must match the next expected word.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {63'd0, out_valid}, 64'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word", {out_instr, out_addr}, exp_w);
                end
            end
        end
    end

    initial begin
        int n;

        // Reset values
        tick(); tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_addr", {32'd0, out_addr}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err_illegal}, 64'd0);
        rst = 1'b0;
        tick();

        // stop in IDLE ignored; start+stop together -> RUN
        pulse_stop();
        check("idle_stop_busy", {63'd0, busy}, 64'd0);
        pulse_start(32'h100, 1'b1);
        exp_addr = 32'h100;
        check("start_wins_busy", {63'd0, busy}, 64'd1);
        check("start_wins_ready", {63'd0, in_ready}, 64'd1);

        // Encoding vectors, consumer always ready
        out_ready = 1'b1;
        push_fs(5'd12, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0,        32'h002081B3, 1'b1); // ADD
        push_fs(5'd12, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0,        32'h402081B3, 1'b1); // SUB
        push_fs(5'd4,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b1); // ADDI
        push_fs(5'd13, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b1); // LUI
        push_fs(5'd24, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h8,        32'h00208463, 1'b1); // BEQ
        push_fs(5'd27, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h10,       32'h010000EF, 1'b1); // JAL
        push_fs(5'd8,  3'd2, 1'b0, 5'd0, 5'd2, 5'd3, 32'h7FC,      32'h7E312E23, 1'b1); // SW
        push_fs(5'd4,  3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'h3,        32'h40315093, 1'b1); // SRAI
        push_fs(5'd25, 3'd3, 1'b0, 5'd1, 5'd5, 5'd0, 32'h4,        32'h004280E7, 1'b1); // JALR
        // start while running must not reload the address
        pulse_start(32'h9000, 1'b0);
        push_fs(5'd0,  3'd2, 1'b0, 5'd2, 5'd3, 5'd0, 32'h10,       32'h0101A103, 1'b1); // LW
        push_fs(5'd5,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF123, 32'hFFFFF097, 1'b1); // AUIPC
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
        push_fs(5'd31, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0,        32'h0,        1'b0);
        check("illegal_pulse", {63'd0, err_illegal}, 64'd1);
        tick();
        check("illegal_pulse_end", {63'd0, err_illegal}, 64'd0);
        push_fs(5'd8,  3'd0, 1'b0, 5'd0, 5'd2, 5'd3, 32'h0,        32'h0,        1'b0);
        check("illegal_sw_pulse", {63'd0, err_illegal}, 64'd1);
`else
        push_fs(5'd31, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0,        32'h403100FF, 1'b1);
        check("no_check_err", {63'd0, err_illegal}, 64'd0);
`endif
        push_fs(5'd4,  3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1,        32'h00100393, 1'b1); // ADDI after
        wait_drain();

        // Backpressure: DEPTH words fill, fifth waits
        out_ready = 1'b0;
        push_fs(5'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1, 32'h00100093, 1'b1);
        push_fs(5'd4, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h2, 32'h00200113, 1'b1);
        push_fs(5'd4, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h3, 32'h00300193, 1'b1);
        check("ready_before_full", {63'd0, in_ready}, 64'd1);
        push_fs(5'd4, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h4, 32'h00400213, 1'b1);
        check("ready_when_full", {63'd0, in_ready}, 64'd0);
        check("valid_when_full", {63'd0, out_valid}, 64'd1);
        tick(); tick();
        check("held_word", {out_instr, out_addr}, exp_q[0]);
        out_ready = 1'b1;
        push_fs(5'd4, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h5, 32'h00500293, 1'b1);
        wait_drain();

        // Stop with words queued; done right after the last pop
        out_ready = 1'b0;
        push_fs(5'd12, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b1);
        push_fs(5'd12, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b1);
        pulse_stop();
        check("drain_busy", {63'd0, busy}, 64'd1);
        check("drain_ready", {63'd0, in_ready}, 64'd0);
        check("drain_no_early_done", {63'd0, done}, 64'd0);
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        check("done_after_last_pop", {63'd0, done}, 64'd1);
        check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
        tick();
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);

        // Address wrap-around
        pulse_start(32'hFFFFFFFC, 1'b0);
        exp_addr = 32'hFFFFFFFC;
        push_fs(5'd13, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b1);
        push_fs(5'd27, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h10,       32'h010000EF, 1'b1);
        wait_drain();
        pulse_stop();
        tick();
        check("wrap_idle", {63'd0, busy}, 64'd0);

        // Reset mid-run with three words queued
        pulse_start(32'h2000, 1'b0);
        exp_addr = 32'h2000;
        out_ready = 1'b0;
        push_fs(5'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1, 32'h00100093, 1'b1);
        push_fs(5'd4, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h2, 32'h00200113, 1'b1);
        push_fs(5'd4, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h3, 32'h00300193, 1'b1);
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_addr", {32'd0, out_addr}, 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_valid", {63'd0, out_valid}, 64'd0);
        end

        // Fresh run after reset starts from its own base
        pulse_start(32'h40, 1'b0);
        exp_addr = 32'h40;
        push_fs(5'd12, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b1);
        wait_drain();
        pulse_stop();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
